// File: rtl/hc595_chain_writer.sv
// hc595_chain_writer: serialises a W-bit word into a chain of 74x595 chips, MSB first, then pulses RCLK.
module hc595_chain_writer #(
  parameter int N_CHIPS = 1,
  parameter int DIV = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*N_CHIPS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_ser,
  output logic                 o_srclk,
  output logic                 o_rclk,
  output logic                 o_oe_n
);
  localparam int W = 8 * N_CHIPS;
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LAT_HI, LAT_LO} state_t;
  state_t r_state, w_nxt;
  logic [W-1:0] r_sr, w_sr;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [7:0] r_div, w_div;
  logic w_end;
  assign w_end = r_div == 8'(DIV - 1);
  always_comb begin
    w_nxt = r_state;
    w_sr = r_sr;
    w_cnt = r_cnt;
    w_div = w_end ? 8'd0 : r_div + 8'd1;
    case (r_state)
      IDLE: begin
        w_div = 8'd0;
        if (i_valid && o_ready) begin
          w_nxt = SH_LO;
          w_sr = i_data;
          w_cnt = CW'(W - 1);
        end
      end
      SH_LO: w_nxt = w_end ? SH_HI : SH_LO;
      SH_HI: if (w_end) begin
        w_sr = r_sr << 1;
        w_nxt = (r_cnt == '0) ? LAT_HI : SH_LO;
        w_cnt = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
      end
      LAT_HI: w_nxt = w_end ? LAT_LO : LAT_HI;
      LAT_LO: w_nxt = w_end ? IDLE : LAT_LO;
      default: w_nxt = IDLE;
    endcase
  end
  // outputs are registered from the next-state decode so they line up with r_state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_cnt <= '0;
      r_div <= '0;
      o_ready <= 1'b0;
      o_ser <= 1'b0;
      o_srclk <= 1'b0;
      o_rclk <= 1'b0;
      o_oe_n <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_sr <= w_sr;
      r_cnt <= w_cnt;
      r_div <= w_div;
      o_ready <= w_nxt == IDLE;
      o_ser <= (w_nxt == SH_LO) ? w_sr[W-1] : o_ser;
      o_srclk <= w_nxt == SH_HI;
      o_rclk <= w_nxt == LAT_HI;
      o_oe_n <= (w_nxt == LAT_LO) ? 1'b0 : o_oe_n;
    end
  end
endmodule

// File: tb/tb_hc595_chain_writer.sv
// tb_hc595_chain_writer: directed vectors for a 1-chip/DIV=1 and a 2-chip/DIV=3 writer with 74x595 chain models.
module tb_hc595_chain_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] data_a = '0;
  logic valid_a = 1'b0;
  logic ready_a, ser_a, srclk_a, rclk_a, oe_n_a;
  logic [15:0] data_b = '0;
  logic valid_b = 1'b0;
  logic ready_b, ser_b, srclk_b, rclk_b, oe_n_b;
  hc595_chain_writer #(.N_CHIPS(1), .DIV(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_ser(ser_a), .o_srclk(srclk_a), .o_rclk(rclk_a), .o_oe_n(oe_n_a));
  hc595_chain_writer #(.N_CHIPS(2), .DIV(3)) u_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_ser(ser_b), .o_srclk(srclk_b), .o_rclk(rclk_b), .o_oe_n(oe_n_b));
  int checks = 0;
  int errors = 0;
  int rises_a = 0, rclks_a = 0, rises_b = 0, rclks_b = 0;
  logic [7:0] sh_a = '0, st_a = '0;
  logic [15:0] sh_b = '0, st_b = '0;
  // 74x595 chain models: shift on SRCLK rise, latch on RCLK rise
  always @(posedge srclk_a) begin
    rises_a++;
    sh_a = {sh_a[6:0], ser_a};
  end
  always @(posedge rclk_a) begin
    rclks_a++;
    st_a = sh_a;
  end
  always @(posedge srclk_b) begin
    rises_b++;
    sh_b = {sh_b[14:0], ser_b};
  end
  always @(posedge rclk_b) begin
    rclks_b++;
    st_b = sh_b;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [7:0] data;
    logic       noisy;
    logic [7:0] exp_st;
    int         exp_low;
    int         exp_rises;
  } vec_t;
  vec_t vecs[5];
  task automatic xfer_a(input vec_t v);
    int r0, c0, low;
    logic ser_hi;
    r0 = rises_a;
    c0 = rclks_a;
    low = 0;
    ser_hi = 1'b0;
    chk("a_ready_before", ready_a, 1);
    data_a = v.data;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    while (!ready_a && low < 1000) begin
      low++;
      if (ser_a) ser_hi = 1'b1;
      if (v.noisy) begin
        data_a = 8'hFF;
        valid_a = ~valid_a;
      end
      @(negedge clk);
    end
    valid_a = 1'b0;
    data_a = '0;
    chk("a_ready_low", low, v.exp_low);
    chk("a_srclk_rises", rises_a - r0, v.exp_rises);
    chk("a_rclk_pulses", rclks_a - c0, 1);
    chk("a_latched", st_a, v.exp_st);
    chk("a_oe_n", oe_n_a, 0);
    if (v.noisy) chk("a_ser_stuck0", ser_hi, 0);
    repeat (3) @(negedge clk);
    chk("a_no_extra_xfer", rclks_a - c0, 1);
  endtask
  initial begin
    int low, low2, hi, hi_run, r0, c0, n;
    logic oe_early;
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 18, 8};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 18, 8};
    vecs[2] = '{8'h5A, 1'b0, 8'h5A, 18, 8};
    vecs[3] = '{8'h80, 1'b0, 8'h80, 18, 8};
    vecs[4] = '{8'h01, 1'b0, 8'h01, 18, 8};
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_a, 0);
    chk("rst_ser", ser_a, 0);
    chk("rst_srclk", srclk_a, 0);
    chk("rst_rclk", rclk_a, 0);
    chk("rst_oe_n", oe_n_a, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", ready_a, 1);
    chk("post_rst_ready_b", ready_b, 1);
    // two chips, DIV=3, 0x8001
    r0 = rises_b;
    c0 = rclks_b;
    low = 0;
    hi_run = 0;
    oe_early = 1'b0;
    data_b = 16'h8001;
    valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    data_b = 16'hFFFF;
    while (!ready_b && low < 1000) begin
      low++;
      if (srclk_b) hi_run++;
      else if (hi_run > 0) begin
        chk("b_srclk_high_len", hi_run, 3);
        hi_run = 0;
      end
      if (!oe_n_b && (rclks_b == c0 || rclk_b)) oe_early = 1'b1;
      @(negedge clk);
    end
    chk("b_ready_low", low, 102);
    chk("b_srclk_rises", rises_b - r0, 16);
    chk("b_rclk_pulses", rclks_b - c0, 1);
    chk("b_latched", st_b, 16'h8001);
    chk("b_oe_n_early", oe_early, 0);
    chk("b_oe_n_after", oe_n_b, 0);
    for (int i = 0; i < 5; i++) xfer_a(vecs[i]);
    // back-to-back 0x3C then 0xFF with VALID held high
    r0 = rises_a;
    c0 = rclks_a;
    low = 0;
    low2 = 0;
    hi = 0;
    data_a = 8'h3C;
    valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'hFF;
    while (!ready_a && low < 1000) begin
      low++;
      @(negedge clk);
    end
    while (ready_a && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    while (!ready_a && low2 < 1000) begin
      low2++;
      @(negedge clk);
    end
    valid_a = 1'b0;
    chk("b2b_low1", low, 18);
    chk("b2b_gap", hi, 1);
    chk("b2b_low2", low2, 18);
    chk("b2b_rises", rises_a - r0, 16);
    chk("b2b_rclks", rclks_a - c0, 2);
    chk("b2b_latched", st_a, 8'hFF);
    @(negedge clk);
    // reset after the 3rd SRCLK rise of 0xA5
    r0 = rises_a;
    c0 = rclks_a;
    n = 0;
    data_a = 8'hA5;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    while (rises_a - r0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_rise3", rises_a - r0, 3);
    chk("abort_ser_before", ser_a, 1);
    rst = 1'b1;
    valid_a = 1'b1;
    @(negedge clk);
    chk("abort_srclk", srclk_a, 0);
    chk("abort_rclk", rclk_a, 0);
    chk("abort_ser", ser_a, 0);
    chk("abort_oe_n", oe_n_a, 1);
    chk("abort_ready", ready_a, 0);
    rst = 1'b0;
    valid_a = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", ready_a, 1);
    repeat (20) @(negedge clk);
    chk("abort_no_rclk", rclks_a - c0, 0);
    chk("abort_oe_n_stays", oe_n_a, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
